// File: rtl/snes_cart_pkg.sv
// Shared types and constants for the SNES cartridge glue logic.
// Used by the BSRAM host arbiter and the surrounding wrapper.
package snes_cart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } arb_state_t;

    localparam int unsigned BSRAM_ADDR_W = 20;
    localparam int unsigned GAP_MAX      = 15;
    localparam int unsigned STARVE_W     = 12;

endpackage

// File: rtl/bsram_host_arb.sv
// Shares the cartridge BSRAM port between the mapper and a host save-file engine.
// The mapper always wins; host byte accesses fill mapper idle gaps and retry when pre-empted.
module bsram_host_arb
    import snes_cart_pkg::*;
#(
    parameter int unsigned ADDR_W        = BSRAM_ADDR_W,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned STARVE_LIMIT  = 4095
) (
    input  logic              MCLK,
    input  logic              RESET,

    input  logic [ADDR_W-1:0] MAP_ADDR,
    input  logic [7:0]        MAP_D,
    input  logic              MAP_CE_N,
    input  logic              MAP_OE_N,
    input  logic              MAP_WE_N,
    output logic [7:0]        MAP_Q,

    input  logic              HOST_REQ,
    input  logic              HOST_WR,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    input  logic [7:0]        HOST_D,
    output logic [7:0]        HOST_Q,
    output logic              HOST_ACK,
    output logic              HOST_STARVE,

    output logic              DIRTY,
    input  logic              DIRTY_CLR,

    output logic [ADDR_W-1:0] BSRAM_ADDR,
    output logic [7:0]        BSRAM_D,
    input  logic [7:0]        BSRAM_Q,
    output logic              BSRAM_CE_N,
    output logic              BSRAM_OE_N,
    output logic              BSRAM_WE_N
);

    localparam logic [STARVE_W-1:0] WAIT_SAT = '1;
    localparam logic [3:0]          GAP_SAT  = 4'(GAP_MAX);
    localparam logic [3:0]          GAP_NEED = 4'(GAP_CYCLES);
    localparam logic [3:0]          ACC_LOAD = 4'(ACCESS_CYCLES - 1);

    arb_state_t          state_q, state_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
    logic [STARVE_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]          acc_cnt_q, acc_cnt_d;
    logic                starve_q, starve_d;
    logic                ack_q, ack_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                map_wr_q;
    logic                dirty_q, dirty_d;

    logic map_busy;
    logic map_wr;
    logic host_own;

    assign map_busy = ~MAP_CE_N & (~MAP_OE_N | ~MAP_WE_N);
    assign map_wr   = ~MAP_CE_N & ~MAP_WE_N;

    // A mapper access in ACCESS takes the port back in the same cycle (abort).
    assign host_own = (state_q == ACCESS) & ~map_busy;

    always_comb begin
        if (host_own) begin
            BSRAM_ADDR = addr_q;
            BSRAM_D    = data_q;
            BSRAM_CE_N = ce_n_q;
            BSRAM_OE_N = oe_n_q;
            BSRAM_WE_N = we_n_q;
        end else begin
            BSRAM_ADDR = MAP_ADDR;
            BSRAM_D    = MAP_D;
            BSRAM_CE_N = MAP_CE_N;
            BSRAM_OE_N = MAP_OE_N;
            BSRAM_WE_N = MAP_WE_N;
        end
    end

    assign MAP_Q       = BSRAM_Q;
    assign HOST_Q      = rdata_q;
    assign HOST_ACK    = ack_q;
    assign HOST_STARVE = starve_q;
    assign DIRTY       = dirty_q;

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (map_busy) begin
            gap_cnt_d = 4'd0;
        end else if (gap_cnt_q != GAP_SAT) begin
            gap_cnt_d = gap_cnt_q + 4'd1;
        end
    end

    // Only the rising edge of the mapper write strobe marks the save dirty; set beats clear.
    always_comb begin
        dirty_d = dirty_q;
        if (map_wr && !map_wr_q) begin
            dirty_d = 1'b1;
        end else if (DIRTY_CLR) begin
            dirty_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        acc_cnt_d  = acc_cnt_q;
        starve_d   = starve_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;

        unique case (state_q)
            IDLE: begin
                // ACK is still high the cycle after DONE, so a held REQ is not re-taken.
                if (HOST_REQ && !ack_q) begin
                    wr_d     = HOST_WR;
                    addr_d   = HOST_ADDR;
                    data_d   = HOST_D;
                    starve_d = 1'b0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q != WAIT_SAT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (32'(wait_cnt_d) >= STARVE_LIMIT) begin
                    starve_d = 1'b1;
                end
                if ((gap_cnt_q >= GAP_NEED) && !map_busy) begin
                    state_d   = ACCESS;
                    acc_cnt_d = ACC_LOAD;
                    ce_n_d    = 1'b0;
                    oe_n_d    = wr_q;
                    we_n_d    = ~wr_q;
                end
            end
            ACCESS: begin
                if (map_busy) begin
                    state_d = WAIT;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                end else if (acc_cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        rdata_d = BSRAM_Q;
                    end
                    state_d = DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                end else begin
                    acc_cnt_d = acc_cnt_q - 4'd1;
                end
            end
            DONE: begin
                ack_d      = 1'b1;
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            gap_cnt_q  <= 4'd0;
            wait_cnt_q <= '0;
            acc_cnt_q  <= 4'd0;
            starve_q   <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= 8'h00;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            map_wr_q   <= 1'b0;
            dirty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            starve_q   <= starve_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            map_wr_q   <= map_wr;
            dirty_q    <= dirty_d;
        end
    end

endmodule

// File: tb/tb_bsram_host_arb.sv
// Directed bench for bsram_host_arb with a small behavioural BSRAM.
// Each task drives one scenario and checks hand-computed expectations inline.
module tb_bsram_host_arb;

    logic        MCLK;
    logic        RESET;
    logic [19:0] MAP_ADDR;
    logic [7:0]  MAP_D;
    logic        MAP_CE_N;
    logic        MAP_OE_N;
    logic        MAP_WE_N;
    logic [7:0]  MAP_Q;
    logic        HOST_REQ;
    logic        HOST_WR;
    logic [19:0] HOST_ADDR;
    logic [7:0]  HOST_D;
    logic [7:0]  HOST_Q;
    logic        HOST_ACK;
    logic        HOST_STARVE;
    logic        DIRTY;
    logic        DIRTY_CLR;
    logic [19:0] BSRAM_ADDR;
    logic [7:0]  BSRAM_D;
    logic [7:0]  BSRAM_Q;
    logic        BSRAM_CE_N;
    logic        BSRAM_OE_N;
    logic        BSRAM_WE_N;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:1023];
    logic       pl_we;
    logic [9:0] pl_addr;
    logic [7:0] pl_data;

    bsram_host_arb #(
        .ADDR_W        (20),
        .ACCESS_CYCLES (2),
        .GAP_CYCLES    (2),
        .STARVE_LIMIT  (4095)
    ) dut (
        .MCLK        (MCLK),
        .RESET       (RESET),
        .MAP_ADDR    (MAP_ADDR),
        .MAP_D       (MAP_D),
        .MAP_CE_N    (MAP_CE_N),
        .MAP_OE_N    (MAP_OE_N),
        .MAP_WE_N    (MAP_WE_N),
        .MAP_Q       (MAP_Q),
        .HOST_REQ    (HOST_REQ),
        .HOST_WR     (HOST_WR),
        .HOST_ADDR   (HOST_ADDR),
        .HOST_D      (HOST_D),
        .HOST_Q      (HOST_Q),
        .HOST_ACK    (HOST_ACK),
        .HOST_STARVE (HOST_STARVE),
        .DIRTY       (DIRTY),
        .DIRTY_CLR   (DIRTY_CLR),
        .BSRAM_ADDR  (BSRAM_ADDR),
        .BSRAM_D     (BSRAM_D),
        .BSRAM_Q     (BSRAM_Q),
        .BSRAM_CE_N  (BSRAM_CE_N),
        .BSRAM_OE_N  (BSRAM_OE_N),
        .BSRAM_WE_N  (BSRAM_WE_N)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // Asynchronous-read, synchronous-write byte memory (low 10 address bits).
    assign BSRAM_Q = mem[BSRAM_ADDR[9:0]];
    always @(posedge MCLK) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (!BSRAM_CE_N && !BSRAM_WE_N) begin
            mem[BSRAM_ADDR[9:0]] <= BSRAM_D;
        end
    end

    task automatic cyc();
        @(posedge MCLK);
        #2;
    endtask

    task automatic map_idle();
        MAP_CE_N = 1'b1;
        MAP_OE_N = 1'b1;
        MAP_WE_N = 1'b1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        cyc();
        pl_we   = 1'b0;
    endtask

    // Issues one host request with the mapper idle; reports ACK cycle and host strobe cycles.
    task automatic run_host(input logic wr, input logic [19:0] a, input logic [7:0] d,
                            output int ack_at, output int low_cnt);
        HOST_WR   = wr;
        HOST_ADDR = a;
        HOST_D    = d;
        HOST_REQ  = 1'b1;
        ack_at    = -1;
        low_cnt   = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (!BSRAM_CE_N && BSRAM_ADDR == a && (wr ? !BSRAM_WE_N : !BSRAM_OE_N)) begin
                low_cnt++;
            end
            if (HOST_ACK) begin
                ack_at   = k;
                HOST_REQ = 1'b0;
                break;
            end
        end
        HOST_REQ = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) cyc();
        checks++; if (HOST_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", HOST_ACK); end
        checks++; if (HOST_Q !== 8'h00) begin errors++; $display("FAIL reset_host_q got=%h exp=00", HOST_Q); end
        checks++; if (HOST_STARVE !== 1'b0) begin errors++; $display("FAIL reset_starve got=%b exp=0", HOST_STARVE); end
        checks++; if (DIRTY !== 1'b0) begin errors++; $display("FAIL reset_dirty got=%b exp=0", DIRTY); end
        checks++;
        if ({BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N} !== 3'b111) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=111", {BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N});
        end
        RESET = 1'b0;
        repeat (20) cyc();
    endtask

    task automatic test_host_read();
        int ack_at, low;
        preload(10'h123, 8'hA5);
        repeat (2) cyc();
        run_host(1'b0, 20'h00123, 8'h00, ack_at, low);
        checks++; if (ack_at != 5) begin errors++; $display("FAIL read_latency got=%0d exp=5", ack_at); end
        checks++; if (low != 2) begin errors++; $display("FAIL read_strobe_cycles got=%0d exp=2", low); end
        checks++; if (HOST_Q !== 8'hA5) begin errors++; $display("FAIL read_data got=%h exp=a5", HOST_Q); end
        cyc();
        checks++; if (HOST_ACK !== 1'b0) begin errors++; $display("FAIL read_ack_width got=%b exp=0", HOST_ACK); end
        repeat (3) cyc();
    endtask

    task automatic test_host_write();
        int ack_at, low;
        run_host(1'b1, 20'h00010, 8'h3C, ack_at, low);
        checks++; if (ack_at != 5) begin errors++; $display("FAIL write_latency got=%0d exp=5", ack_at); end
        checks++; if (low != 2) begin errors++; $display("FAIL write_strobe_cycles got=%0d exp=2", low); end
        cyc();
        checks++; if (mem[10'h010] !== 8'h3C) begin errors++; $display("FAIL write_mem got=%h exp=3c", mem[10'h010]); end
        MAP_ADDR = 20'h00010;
        MAP_CE_N = 1'b0;
        MAP_OE_N = 1'b0;
        #1;
        checks++; if (MAP_Q !== 8'h3C) begin errors++; $display("FAIL write_map_readback got=%h exp=3c", MAP_Q); end
        checks++; if (DIRTY !== 1'b0) begin errors++; $display("FAIL write_no_dirty got=%b exp=0", DIRTY); end
        cyc();
        map_idle();
        repeat (4) cyc();
    endtask

    task automatic test_abort();
        int ack_at, low;
        logic pre_ok;
        preload(10'h055, 8'h5A);
        repeat (3) cyc();
        HOST_WR   = 1'b0;
        HOST_ADDR = 20'h00055;
        HOST_REQ  = 1'b1;
        ack_at    = -1;
        low       = 0;
        pre_ok    = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 3) begin
                MAP_ADDR = 20'h00200;
                MAP_CE_N = 1'b0;
                MAP_OE_N = 1'b0;
            end
            if (k == 4) map_idle();
            #1;
            if (k == 3) begin
                pre_ok = (BSRAM_ADDR == 20'h00200) && !BSRAM_CE_N && !BSRAM_OE_N && BSRAM_WE_N;
            end
            if (!BSRAM_CE_N && !BSRAM_OE_N && BSRAM_ADDR == 20'h00055) low++;
            if (HOST_ACK) begin
                ack_at   = k;
                HOST_REQ = 1'b0;
                break;
            end
        end
        HOST_REQ = 1'b0;
        checks++; if (pre_ok !== 1'b1) begin errors++; $display("FAIL abort_mapper_wins got=%b exp=1", pre_ok); end
        checks++; if (ack_at != 10) begin errors++; $display("FAIL abort_retry_latency got=%0d exp=10", ack_at); end
        checks++; if (low != 3) begin errors++; $display("FAIL abort_host_strobe_cycles got=%0d exp=3", low); end
        checks++; if (HOST_Q !== 8'h5A) begin errors++; $display("FAIL abort_retry_data got=%h exp=5a", HOST_Q); end
        repeat (3) cyc();
    endtask

    task automatic test_starve();
        int first, spurious, ack_at;
        MAP_ADDR  = 20'h00000;
        MAP_CE_N  = 1'b0;
        MAP_OE_N  = 1'b0;
        HOST_WR   = 1'b0;
        HOST_ADDR = 20'h00123;
        HOST_REQ  = 1'b1;
        first     = -1;
        spurious  = 0;
        for (int k = 1; k <= 5000; k++) begin
            cyc();
            if (HOST_STARVE && first < 0) first = k;
            if (HOST_ACK) spurious++;
            if (BSRAM_ADDR == 20'h00123) spurious++;
        end
        checks++; if (first != 4096) begin errors++; $display("FAIL starve_cycle got=%0d exp=4096", first); end
        checks++; if (spurious != 0) begin errors++; $display("FAIL starve_no_host got=%0d exp=0", spurious); end
        map_idle();
        ack_at = -1;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (HOST_ACK) begin
                ack_at   = k;
                HOST_REQ = 1'b0;
                break;
            end
        end
        HOST_REQ = 1'b0;
        checks++; if (ack_at != 6) begin errors++; $display("FAIL starve_ack_after_idle got=%0d exp=6", ack_at); end
        checks++; if (HOST_Q !== 8'hA5) begin errors++; $display("FAIL starve_data got=%h exp=a5", HOST_Q); end
        checks++; if (HOST_STARVE !== 1'b1) begin errors++; $display("FAIL starve_sticky got=%b exp=1", HOST_STARVE); end
        repeat (3) cyc();
    endtask

    task automatic test_dirty();
        checks++; if (DIRTY !== 1'b0) begin errors++; $display("FAIL dirty_initial got=%b exp=0", DIRTY); end
        MAP_ADDR = 20'h00200;
        MAP_D    = 8'h77;
        MAP_CE_N = 1'b0;
        MAP_WE_N = 1'b0;
        cyc();
        checks++; if (DIRTY !== 1'b1) begin errors++; $display("FAIL dirty_set got=%b exp=1", DIRTY); end
        map_idle();
        cyc();
        MAP_CE_N  = 1'b0;
        MAP_WE_N  = 1'b0;
        DIRTY_CLR = 1'b1;
        cyc();
        checks++; if (DIRTY !== 1'b1) begin errors++; $display("FAIL dirty_set_wins got=%b exp=1", DIRTY); end
        map_idle();
        cyc();
        checks++; if (DIRTY !== 1'b0) begin errors++; $display("FAIL dirty_clear got=%b exp=0", DIRTY); end
        DIRTY_CLR = 1'b0;
        checks++; if (mem[10'h200] !== 8'h77) begin errors++; $display("FAIL dirty_mem got=%h exp=77", mem[10'h200]); end
        repeat (3) cyc();
    endtask

    task automatic test_reset_mid_access();
        int bad, ack_at, low;
        preload(10'h040, 8'h00);
        MAP_ADDR = 20'h00201;
        MAP_CE_N = 1'b0;
        MAP_WE_N = 1'b0;
        cyc();
        map_idle();
        repeat (3) cyc();
        checks++; if (DIRTY !== 1'b1) begin errors++; $display("FAIL rst_pre_dirty got=%b exp=1", DIRTY); end
        HOST_WR   = 1'b1;
        HOST_ADDR = 20'h00040;
        HOST_D    = 8'h99;
        HOST_REQ  = 1'b1;
        cyc();
        cyc();
        #1;
        checks++;
        if ({BSRAM_CE_N, BSRAM_WE_N} !== 2'b00) begin
            errors++;
            $display("FAIL rst_pre_access got=%b exp=00", {BSRAM_CE_N, BSRAM_WE_N});
        end
        RESET = 1'b1;
        #1;
        checks++;
        if ({BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N} !== 3'b111) begin
            errors++;
            $display("FAIL rst_strobes got=%b exp=111", {BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N});
        end
        checks++; if (HOST_ACK !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", HOST_ACK); end
        checks++; if (DIRTY !== 1'b0) begin errors++; $display("FAIL rst_dirty got=%b exp=0", DIRTY); end
        checks++; if (HOST_STARVE !== 1'b0) begin errors++; $display("FAIL rst_starve got=%b exp=0", HOST_STARVE); end
        checks++; if (HOST_Q !== 8'h00) begin errors++; $display("FAIL rst_host_q got=%h exp=00", HOST_Q); end
        HOST_REQ = 1'b0;
        cyc();
        RESET = 1'b0;
        bad   = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (HOST_ACK || !BSRAM_CE_N) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_quiet_after got=%0d exp=0", bad); end
        checks++; if (mem[10'h040] !== 8'h00) begin errors++; $display("FAIL rst_no_write got=%h exp=00", mem[10'h040]); end
        run_host(1'b0, 20'h00123, 8'h00, ack_at, low);
        checks++; if (ack_at != 5) begin errors++; $display("FAIL rst_idle_latency got=%0d exp=5", ack_at); end
        checks++; if (HOST_Q !== 8'hA5) begin errors++; $display("FAIL rst_idle_data got=%h exp=a5", HOST_Q); end
        repeat (2) cyc();
    endtask

    initial begin
        RESET     = 1'b1;
        MAP_ADDR  = '0;
        MAP_D     = 8'h00;
        MAP_CE_N  = 1'b1;
        MAP_OE_N  = 1'b1;
        MAP_WE_N  = 1'b1;
        HOST_REQ  = 1'b0;
        HOST_WR   = 1'b0;
        HOST_ADDR = '0;
        HOST_D    = 8'h00;
        DIRTY_CLR = 1'b0;
        pl_we     = 1'b0;
        pl_addr   = '0;
        pl_data   = 8'h00;

        test_reset();
        test_host_read();
        test_host_write();
        test_abort();
        test_starve();
        test_dirty();
        test_reset_mid_access();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bsram_host_arb.md
Name: bsram_host_arb

Overview:
- Shares the single cartridge BSRAM port between the active mapper's BSRAM signals and a host-side save-file transfer engine, which loads and stores .srm files through the HPS.
- Sits between the mapper output mux in the top-level SNES wrapper and the physical BSRAM.
- The mapper always has priority. Host byte accesses are slotted into mapper idle gaps; a host access that is pre-empted is aborted and retried.
- Also tracks mapper writes as a dirty flag, used to trigger autosave.

Parameters:
- ADDR_W, 20, BSRAM byte address width.
- ACCESS_CYCLES, 2, MCLK cycles the host access holds CE_N/OE_N or CE_N/WE_N low (range 1..15).
- GAP_CYCLES, 2, consecutive mapper-idle cycles required before a host slot may start (range 1..15).
- STARVE_LIMIT, 4095, wait cycles after which HOST_STARVE is flagged (12-bit counter).

Ports:
- MCLK  in  1  system clock
- RESET  in  1  asynchronous active-high reset
- MAP_ADDR  in  ADDR_W  mapper BSRAM address
- MAP_D  in  8  mapper write data
- MAP_CE_N  in  1  mapper chip enable
- MAP_OE_N  in  1  mapper output enable
- MAP_WE_N  in  1  mapper write enable
- MAP_Q  out  8  read data returned to mapper (BSRAM_Q passthrough)
- HOST_REQ  in  1  host access request (level; held until HOST_ACK)
- HOST_WR  in  1  1=write, 0=read; sampled with HOST_REQ
- HOST_ADDR  in  ADDR_W  host byte address
- HOST_D  in  8  host write data
- HOST_Q  out  8  host read data, valid when HOST_ACK=1
- HOST_ACK  out  1  one-cycle completion pulse
- HOST_STARVE  out  1  sticky; waited > STARVE_LIMIT cycles
- DIRTY  out  1  mapper has written BSRAM since last clear
- DIRTY_CLR  in  1  clears DIRTY
- BSRAM_ADDR  out  ADDR_W  to memory
- BSRAM_D  out  8  to memory
- BSRAM_Q  in  8  from memory
- BSRAM_CE_N  out  1  to memory
- BSRAM_OE_N  out  1  to memory
- BSRAM_WE_N  out  1  to memory

Behaviour:
Reset values:
- On RESET: state IDLE, HOST_ACK=0, HOST_Q=0, HOST_STARVE=0, DIRTY=0, all counters 0.
- Host output registers on reset: addr 0, d 0, CE_N/OE_N/WE_N = 1.

Ownership and output mux:
- Owner is host only in state ACCESS; otherwise mapper.
- Mapper ownership: BSRAM_* = MAP_* combinationally, so the mapper path has zero added latency.
- Host ownership: BSRAM_* come from registers.
- MAP_Q = BSRAM_Q at all times.

Mapper activity and gap counter:
- map_busy = ~MAP_CE_N & (~MAP_OE_N | ~MAP_WE_N).
- gap_cnt increments (saturating at 15) while ~map_busy; it is cleared when map_busy.

State machine:
- IDLE: when HOST_REQ=1 and HOST_ACK=0, latch HOST_WR, HOST_ADDR and HOST_D, then go to WAIT.
- WAIT:
  - wait_cnt increments, saturating at 4095.
  - When wait_cnt reaches STARVE_LIMIT, set HOST_STARVE.
  - If gap_cnt >= GAP_CYCLES and map_busy=0 this cycle, go to ACCESS and load acc_cnt = ACCESS_CYCLES-1.
- ACCESS:
  - Registered outputs: CE_N=0, OE_N=wr, WE_N=~wr.
  - If map_busy rises during ACCESS: abort. Deassert the host strobes in the same cycle via the combinational mux; the mapper wins. Return to WAIT without ACK. The latched request is kept.
  - Otherwise decrement acc_cnt. At acc_cnt=0:
    - on a read, capture BSRAM_Q into HOST_Q;
    - go to DONE.
- DONE: pulse HOST_ACK for exactly 1 cycle, clear wait_cnt, go to IDLE.

Handshake rules:
- HOST_REQ must drop the cycle after HOST_ACK. A request still high in IDLE while ACK=0 starts a new access.
- Minimum access latency (REQ to ACK) with the mapper idle: 1 (latch) + 1 (WAIT) + ACCESS_CYCLES + 1 (DONE) = 5 cycles at default ACCESS_CYCLES=2.

HOST_STARVE:
- Cleared on each new IDLE to WAIT transition.
- Otherwise sticky.

DIRTY:
- Set on the cycle ~MAP_CE_N & ~MAP_WE_N is first seen (rising edge of the write strobe).
- DIRTY_CLR clears it.
- Simultaneous set and clear: set wins.
- Host writes never set DIRTY.

Other boundary conditions:
- An abort in the final ACCESS cycle still aborts; no partial ACK.
- RESET mid-ACCESS returns the strobes high immediately (asynchronous) and produces no ACK.

Decomposition:
- Shared package snes_cart_pkg: arb_state_t enum {IDLE, WAIT, ACCESS, DONE}; constants BSRAM_ADDR_W=20, GAP_MAX=15, STARVE_W=12.
- No sub-module needed. The gap/starve counters and the mux are inline.

Test Plan:
- Mapper idle; host read, addr 0x00123, mem[0x00123]=0xA5 -> BSRAM_CE_N/OE_N low for 2 cycles; HOST_ACK at cycle 5 after REQ; HOST_Q=0xA5.
- Host write 0x3C to 0x00010 with mapper idle -> WE_N low 2 cycles; later mapper read of 0x00010 returns 0x3C; DIRTY remains 0.
- Mapper asserts CE_N/OE_N in the 2nd ACCESS cycle -> BSRAM shows the mapper address that same cycle; no ACK; the host access retries after 2 idle cycles and ACKs with correct data.
- Mapper busy continuously for 5000 cycles while HOST_REQ is high -> HOST_STARVE=1 at wait cycle 4095; no host strobes; ACK follows once the mapper goes idle.
- Mapper write to 0x00200 -> DIRTY=1 next cycle. DIRTY_CLR asserted together with a new mapper write -> DIRTY stays 1. DIRTY_CLR alone -> DIRTY=0.
- RESET asserted mid-ACCESS -> BSRAM_CE_N/OE_N/WE_N=1 immediately; HOST_ACK, DIRTY and HOST_STARVE are 0; state IDLE after release.
